// File: rtl/nibble_serial_adder_if.sv
// Operand/result bundle for nibble_serial_adder.
// The ovf signal exists only when NSA_OVERFLOW_EN is defined.
interface nibble_serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef NSA_OVERFLOW_EN
    logic             ovf;

    modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
`else
    modport master (output start, a, b, cin, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one 4-bit carry-lookahead cell used LSB nibble first.
// Define NSA_OVERFLOW_EN to add the registered signed-overflow output (ovf).

module carry_lookahead_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       carry
);
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is a flat generate/propagate product, so there is no ripple path.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign carry = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                 | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

    assign sum = p ^ c;
endmodule

module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    nibble_serial_adder_if.slave  bus
);
    localparam int N  = WIDTH / 4;
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] psum;
    logic [WIDTH-1:0] sum_q;
    logic [CW-1:0]    count;
    logic             carry_q;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;
    logic [3:0]       nib_sum;
    logic             nib_carry;
    logic [WIDTH-1:0] psum_next;

    carry_lookahead_adder u_cla (
        .a     (op_a[3:0]),
        .b     (op_b[3:0]),
        .cin   (carry_q),
        .sum   (nib_sum),
        .carry (nib_carry)
    );

    // New nibble enters at the top; after N shifts the first nibble lands at bit 0.
    assign psum_next = {nib_sum, psum[WIDTH-1:4]};

`ifdef NSA_OVERFLOW_EN
    logic ovf_q;
`endif

    // NOTE: all state below uses non-blocking assignments so every register
    // sees the pre-edge value of every other register, matching the hardware.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            op_a    <= '0;
            op_b    <= '0;
            psum    <= '0;
            sum_q   <= '0;
            count   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef NSA_OVERFLOW_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_a    <= bus.a;
                        op_b    <= bus.b;
                        carry_q <= bus.cin;
                        psum    <= '0;
                        count   <= '0;
                        busy_q  <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    psum    <= psum_next;
                    carry_q <= nib_carry;
                    op_a    <= op_a >> 4;
                    op_b    <= op_b >> 4;
                    count   <= count + 1'b1;
                    if (count == LAST) begin
                        sum_q  <= psum_next;
                        cout_q <= nib_carry;
`ifdef NSA_OVERFLOW_EN
                        // Carry into the MSB is recovered from the top bit's half-sum.
                        ovf_q  <= op_a[3] ^ op_b[3] ^ nib_sum[3] ^ nib_carry;
`endif
                        count  <= '0;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
`ifdef NSA_OVERFLOW_EN
    assign bus.ovf  = ovf_q;
`endif
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder: directed cases plus randomized adds
// compared against an arithmetic reference model.
module tb_nibble_serial_adder;
    localparam int WIDTH = 16;
    localparam int N     = WIDTH / 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    nibble_serial_adder_if #(.WIDTH(WIDTH)) bus ();
    nibble_serial_adder #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int passed = 0;

    logic [WIDTH-1:0] exp_sum  = '0;
    logic             exp_cout = 1'b0;
    logic             exp_ovf  = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain unsigned and signed arithmetic on whole operands.
    task automatic model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
        logic [WIDTH:0] full;
        longint sa, sb, s, smax, smin;
        full     = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
        exp_sum  = full[WIDTH-1:0];
        exp_cout = full[WIDTH];
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        s    = sa + sb + longint'(c);
        smax = (longint'(1) <<< (WIDTH - 1)) - 1;
        smin = -(longint'(1) <<< (WIDTH - 1));
        exp_ovf = (s > smax) || (s < smin);
    endtask

    // mode 0: quiet inputs while busy; 1: random noise on all inputs while busy;
    // 2: pulse start with zero operands before the second run edge.
    task automatic run_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic c, input string tag, input int mode);
        logic [WIDTH-1:0] prev_sum;
        logic             prev_cout;
        int               cycles;
        bit               got;
        bit               mid_ok;
        prev_sum  = exp_sum;
        prev_cout = exp_cout;
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.cin   = c;
        step();
        bus.start = 1'b0;
        check({tag, ".busy_after_start"}, 64'(bus.busy), 64'd1);
        model(a, b, c);
        cycles = 0;
        got    = 1'b0;
        mid_ok = 1'b1;
        while (cycles < N + 4 && !got) begin
            if (mode == 1) begin
                bus.a     = WIDTH'($urandom);
                bus.b     = WIDTH'($urandom);
                bus.cin   = 1'($urandom);
                bus.start = 1'($urandom);
            end else if (mode == 2) begin
                bus.start = (cycles == 1);
                if (cycles == 1) begin
                    bus.a   = '0;
                    bus.b   = '0;
                    bus.cin = 1'b0;
                end
            end
            step();
            cycles++;
            if (bus.done === 1'b1) got = 1'b1;
            else if (bus.sum !== prev_sum || bus.cout !== prev_cout || bus.busy !== 1'b1)
                mid_ok = 1'b0;
        end
        bus.start = 1'b0;
        check({tag, ".latency"}, 64'(cycles), 64'(N));
        check({tag, ".hold_while_busy"}, 64'(mid_ok), 64'd1);
        check({tag, ".busy_at_done"}, 64'(bus.busy), 64'd0);
        check({tag, ".sum"}, 64'(bus.sum), 64'(exp_sum));
        check({tag, ".cout"}, 64'(bus.cout), 64'(exp_cout));
`ifdef NSA_OVERFLOW_EN
        check({tag, ".ovf"}, 64'(bus.ovf), 64'(exp_ovf));
`endif
    endtask

    initial begin
        int done_seen;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("reset.busy", 64'(bus.busy), 64'd0);
        check("reset.done", 64'(bus.done), 64'd0);
        check("reset.sum", 64'(bus.sum), 64'd0);
        check("reset.cout", 64'(bus.cout), 64'd0);
`ifdef NSA_OVERFLOW_EN
        check("reset.ovf", 64'(bus.ovf), 64'd0);
`endif
        step();

        // Basic add with an ignored start pulse mid-operation.
        run_add(16'h1234, 16'h4321, 1'b0, "t1", 2);
        check("t1.sum_const", 64'(bus.sum), 64'h5555);
        step();
        check("t1.done_one_cycle", 64'(bus.done), 64'd0);
        check("t1.sum_held", 64'(bus.sum), 64'h5555);
        check("t1.no_restart", 64'(bus.busy), 64'd0);

        run_add(16'hFFFF, 16'h0001, 1'b0, "t2", 0);
        check("t2.sum_const", 64'(bus.sum), 64'h0000);
        check("t2.cout_const", 64'(bus.cout), 64'd1);
        step();

        // Back-to-back: second start is driven in the done cycle.
        run_add(16'hFFFF, 16'hFFFF, 1'b1, "t3a", 0);
        check("t3a.sum_const", 64'(bus.sum), 64'hFFFF);
        run_add(16'h0003, 16'h0004, 1'b0, "t3b", 0);
        check("t3b.sum_const", 64'(bus.sum), 64'h0007);
        check("t3b.cout_const", 64'(bus.cout), 64'd0);
        step();

        // Reset mid-operation aborts without a done pulse.
        bus.start = 1'b1;
        bus.a     = 16'hABCD;
        bus.b     = 16'h1111;
        bus.cin   = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5.busy", 64'(bus.busy), 64'd0);
        check("t5.done", 64'(bus.done), 64'd0);
        check("t5.sum", 64'(bus.sum), 64'd0);
        check("t5.cout", 64'(bus.cout), 64'd0);
        done_seen = 0;
        for (int i = 0; i < 2 * N; i++) begin
            step();
            if (bus.done === 1'b1) done_seen++;
        end
        check("t5.no_done_pulse", 64'(done_seen), 64'd0);
        exp_sum  = '0;
        exp_cout = 1'b0;
        exp_ovf  = 1'b0;

        // Signed-overflow corner cases.
        run_add(16'h7FFF, 16'h0001, 1'b0, "t6a", 0);
        run_add(16'h8000, 16'h8000, 1'b0, "t6b", 0);
        step();

        // Randomized adds with noisy inputs while busy and random idle gaps.
        for (int i = 0; i < 20; i++) begin
            run_add(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), $sformatf("rnd%0d", i), 1);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) step();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
